// File: rtl/debug_rom_pkg.sv
// Shared definitions for the debug ROM and its instruction-fetch front end.
package debug_rom_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HIT_RSP,
        ERR_RSP,
        ROM_REQ,
        ROM_RSP
    } fetch_state_e;

    // Debug ROM placement and depth, shared with debug_rom.
    localparam logic [63:0] DbgRomBase = 64'h0000_0000_0000_0800;
    localparam int unsigned DbgRomSize = 20;

    // 64-bit line index of a byte offset into the ROM.
    function automatic logic [63:0] rom_line_idx(input logic [63:0] off);
        return off >> 3;
    endfunction

    // Little-endian 32-bit half of a 64-bit ROM line.
    function automatic logic [31:0] rom_half(input logic [63:0] line, input logic hi);
        return hi ? line[63:32] : line[31:0];
    endfunction

endpackage

// File: rtl/debug_rom_linebuf.sv
// Single-line buffer for debug ROM fetches: data, tag, valid, hit compare
// and 32-bit half select.
module debug_rom_linebuf
    import debug_rom_pkg::*;
#(
    parameter int unsigned TagW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            wr_en,
    input  logic [TagW-1:0] wr_tag,
    input  logic [63:0]     wr_data,
    input  logic [TagW-1:0] lookup_tag,
    input  logic            half_sel,
    output logic            hit,
    output logic [31:0]     rdata
);

    logic            valid;
    logic [TagW-1:0] tag;
    logic [63:0]     data;

    // Valid bit: flush wins over a fill in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (wr_en) begin
            valid <= 1'b1;
        end
    end

    // Line data and tag are only written by an unflushed fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag  <= '0;
            data <= '0;
        end else if (wr_en && !flush) begin
            tag  <= wr_tag;
            data <= wr_data;
        end
    end

    assign hit   = valid && (tag == lookup_tag);
    assign rdata = rom_half(data, half_sel);

endmodule

// File: rtl/debug_rom_fetch.sv
// Debug ROM instruction-fetch initiator: turns 32-bit hart fetches into
// 64-bit one-cycle-latency ROM reads, with a one-line buffer for sequential
// fetches and error responses for out-of-range or misaligned addresses.
module debug_rom_fetch
    import debug_rom_pkg::*;
#(
    parameter int unsigned          AddrWidth = 64,
    parameter logic [AddrWidth-1:0] BaseAddr  = AddrWidth'(DbgRomBase),
    parameter int unsigned          RomSize   = DbgRomSize
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 fetch_req_i,
    input  logic [AddrWidth-1:0] fetch_addr_i,
    output logic                 fetch_gnt_o,
    output logic                 fetch_rvalid_o,
    output logic [31:0]          fetch_rdata_o,
    output logic                 fetch_err_o,
    output logic                 rom_req_o,
    output logic [AddrWidth-1:0] rom_addr_o,
    input  logic [63:0]          rom_rdata_i
);

    localparam int unsigned          TagW     = (RomSize > 1) ? $clog2(RomSize) : 1;
    localparam logic [AddrWidth-1:0] RomBytes = AddrWidth'(RomSize * 8);
    localparam logic [AddrWidth-1:0] LineMask = ~AddrWidth'(7);

    fetch_state_e         state, state_next;
    logic [AddrWidth-1:0] addr_q;
    logic [AddrWidth-1:0] off_in, off_q;
    logic                 in_range, aligned, accept;
    logic                 hit, buf_wr;
    logic [TagW-1:0]      tag_in, tag_q;
    logic [31:0]          buf_half;

    // Offset checks on the incoming address. The compare against BaseAddr
    // keeps addresses below the ROM from wrapping into a small offset.
    assign off_in   = fetch_addr_i - BaseAddr;
    assign in_range = (fetch_addr_i >= BaseAddr) && (off_in < RomBytes);
    assign aligned  = (fetch_addr_i[1:0] == 2'b00);
    assign tag_in   = TagW'(rom_line_idx(64'(off_in)));

    // Captured fetch drives the ROM line address, fill tag and half select.
    assign off_q = addr_q - BaseAddr;
    assign tag_q = TagW'(rom_line_idx(64'(off_q)));

    debug_rom_linebuf #(
        .TagW (TagW)
    ) u_linebuf (
        .clk        (clk_i),
        .rst        (rst_i),
        .flush      (flush_i),
        .wr_en      (buf_wr),
        .wr_tag     (tag_q),
        .wr_data    (rom_rdata_i),
        .lookup_tag (tag_in),
        .half_sel   (off_q[2]),
        .hit        (hit),
        .rdata      (buf_half)
    );

    // Grant is also masked by reset so every output reads 0 while rst_i is high.
    assign fetch_gnt_o = (state == IDLE) && !flush_i && !rst_i;
    assign accept      = fetch_req_i && fetch_gnt_o;

    // State register and captured fetch address.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            addr_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q <= fetch_addr_i;
            end
        end
    end

    // Next state and response/ROM outputs; flush suppresses any response.
    always_comb begin
        state_next     = state;
        fetch_rvalid_o = 1'b0;
        fetch_rdata_o  = '0;
        fetch_err_o    = 1'b0;
        rom_req_o      = 1'b0;
        rom_addr_o     = '0;
        buf_wr         = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (!in_range || !aligned) begin
                        state_next = ERR_RSP;
                    end else if (hit) begin
                        state_next = HIT_RSP;
                    end else begin
                        state_next = ROM_REQ;
                    end
                end
            end
            HIT_RSP: begin
                if (!flush_i) begin
                    fetch_rvalid_o = 1'b1;
                    fetch_rdata_o  = buf_half;
                end
                state_next = IDLE;
            end
            ERR_RSP: begin
                if (!flush_i) begin
                    fetch_rvalid_o = 1'b1;
                    fetch_err_o    = 1'b1;
                end
                state_next = IDLE;
            end
            ROM_REQ: begin
                // The read still goes out under flush; its data is dropped.
                rom_req_o  = 1'b1;
                rom_addr_o = BaseAddr + (off_q & LineMask);
                state_next = flush_i ? IDLE : ROM_RSP;
            end
            ROM_RSP: begin
                if (!flush_i) begin
                    fetch_rvalid_o = 1'b1;
                    fetch_rdata_o  = rom_half(rom_rdata_i, off_q[2]);
                    buf_wr         = 1'b1;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_debug_rom_fetch.sv
// Self-checking bench for debug_rom_fetch: directed scenarios from the
// fetch rules plus randomized fetches against a line-buffer model.
module tb_debug_rom_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        fetch_req;
    logic [63:0] fetch_addr;
    logic        gnt, rvalid, err, rom_req;
    logic [31:0] rdata;
    logic [63:0] rom_addr;
    logic [63:0] rom_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mem [20];
    logic        m_valid;
    logic [63:0] m_line;
    logic [63:0] rom_idx;

    always #5 clk = ~clk;

    debug_rom_fetch dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .fetch_req_i    (fetch_req),
        .fetch_addr_i   (fetch_addr),
        .fetch_gnt_o    (gnt),
        .fetch_rvalid_o (rvalid),
        .fetch_rdata_o  (rdata),
        .fetch_err_o    (err),
        .rom_req_o      (rom_req),
        .rom_addr_o     (rom_addr),
        .rom_rdata_i    (rom_rdata)
    );

    // ROM: one-cycle read latency, holds data when not requested.
    assign rom_idx = (rom_addr - 64'h800) >> 3;
    always @(posedge clk) begin
        if (rom_req) rom_rdata <= (rom_idx < 64'd20) ? mem[rom_idx[4:0]] : 64'hDEAD_BEEF_DEAD_BEEF;
    end

    // Reference: classify a fetch and update the one-line buffer model.
    task automatic model_fetch(input logic [63:0] a, output int lat, output logic [31:0] rd,
                               output logic er, output int nrom, output logic [63:0] raddr);
        logic [63:0] off;
        logic [63:0] line;
        logic [63:0] word;
        off   = a - 64'h800;
        raddr = 64'h0;
        if (a < 64'h800 || off >= 64'd160 || a[1:0] != 2'b00) begin
            lat = 1; rd = 32'h0; er = 1'b1; nrom = 0;
        end else begin
            line = off / 8;
            word = mem[line[4:0]];
            rd   = off[2] ? word[63:32] : word[31:0];
            er   = 1'b0;
            if (m_valid && m_line == line) begin
                lat = 1; nrom = 0;
            end else begin
                lat = 2; nrom = 1; raddr = 64'h800 + line * 8;
                m_valid = 1'b1; m_line = line;
            end
        end
    endtask

    // Issue one fetch and observe the following four cycles.
    task automatic do_fetch(input logic [63:0] a, output logic g, output int lat, output logic [31:0] rd,
                            output logic er, output int nrom, output logic [63:0] raddr,
                            output int nrv, output int nviol);
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = a;
        #1 g = gnt;
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0; fetch_addr = {$urandom, $urandom};
        lat = 0; rd = '0; er = 1'b0; nrom = 0; raddr = '0; nrv = 0; nviol = 0;
        for (int c = 1; c <= 4; c++) begin
            if (rom_req) begin nrom++; raddr = rom_addr; end
            else if (rom_addr !== 64'h0) nviol++;
            if (rvalid) begin
                nrv++;
                if (lat == 0) begin lat = c; rd = rdata; er = err; end
            end else if (rdata !== 32'h0 || err !== 1'b0) nviol++;
            if (c < 4) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; fetch_req = 1'b1; fetch_addr = 64'h800;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (gnt !== 1'b0)      begin n_fail++; $display("FAIL reset gnt: got %0b want 0", gnt); end
        n_checks++; if (rvalid !== 1'b0)   begin n_fail++; $display("FAIL reset rvalid: got %0b want 0", rvalid); end
        n_checks++; if (rdata !== 32'h0)   begin n_fail++; $display("FAIL reset rdata: got %h want 0", rdata); end
        n_checks++; if (err !== 1'b0)      begin n_fail++; $display("FAIL reset err: got %0b want 0", err); end
        n_checks++; if (rom_req !== 1'b0)  begin n_fail++; $display("FAIL reset rom_req: got %0b want 0", rom_req); end
        n_checks++; if (rom_addr !== 64'h0) begin n_fail++; $display("FAIL reset rom_addr: got %h want 0", rom_addr); end
        fetch_req = 1'b0;
        @(negedge clk); rst = 1'b0; #1;
        n_checks++; if (gnt !== 1'b1)      begin n_fail++; $display("FAIL reset_release gnt: got %0b want 1", gnt); end
        m_valid = 1'b0; m_line = '0;
    endtask

    task automatic test_fetch_list(input string name, input logic [63:0] addrs [$]);
        logic g, er, e_er; logic [31:0] rd, e_rd; logic [63:0] ra, e_ra;
        int lat, nrom, nrv, nviol, e_lat, e_nrom;
        foreach (addrs[i]) begin
            model_fetch(addrs[i], e_lat, e_rd, e_er, e_nrom, e_ra);
            do_fetch(addrs[i], g, lat, rd, er, nrom, ra, nrv, nviol);
            n_checks++; if (g !== 1'b1)   begin n_fail++; $display("FAIL %s gnt @%h: got %0b want 1", name, addrs[i], g); end
            n_checks++; if (lat != e_lat) begin n_fail++; $display("FAIL %s latency @%h: got %0d want %0d", name, addrs[i], lat, e_lat); end
            n_checks++; if (rd !== e_rd)  begin n_fail++; $display("FAIL %s rdata @%h: got %h want %h", name, addrs[i], rd, e_rd); end
            n_checks++; if (er !== e_er)  begin n_fail++; $display("FAIL %s err @%h: got %0b want %0b", name, addrs[i], er, e_er); end
            n_checks++; if (nrom != e_nrom) begin n_fail++; $display("FAIL %s rom_reqs @%h: got %0d want %0d", name, addrs[i], nrom, e_nrom); end
            if (e_nrom == 1) begin
                n_checks++; if (ra !== e_ra) begin n_fail++; $display("FAIL %s rom_addr @%h: got %h want %h", name, addrs[i], ra, e_ra); end
            end
            n_checks++; if (nrv != 1 || nviol != 0) begin n_fail++; $display("FAIL %s protocol @%h: rvalids %0d idle-nonzero %0d want 1/0", name, addrs[i], nrv, nviol); end
        end
    endtask

    task automatic test_cold_and_hit();
        logic [63:0] a [$];
        a = '{64'h800, 64'h804};
        test_fetch_list("cold_hit", a);
    endtask

    task automatic test_last_word();
        logic [63:0] a [$];
        a = '{64'h89C, 64'h898};
        test_fetch_list("last_word", a);
    endtask

    task automatic test_errors();
        logic [63:0] a [$];
        a = '{64'h8A0, 64'h7FC, 64'h802, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h89E};
        test_fetch_list("errors", a);
    endtask

    task automatic test_flush_rsp();
        logic [63:0] a [$];
        @(negedge clk); fetch_req = 1'b1; fetch_addr = 64'h810;
        @(posedge clk);
        @(negedge clk); fetch_req = 1'b0;
        n_checks++; if (rom_req !== 1'b1 || rom_addr !== 64'h810) begin n_fail++; $display("FAIL flush_rsp rom_req: got %0b/%h want 1/810", rom_req, rom_addr); end
        @(negedge clk); flush = 1'b1; #1;
        n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL flush_rsp rvalid: got %0b want 0", rvalid); end
        @(negedge clk); flush = 1'b0; #1;
        n_checks++; if (gnt !== 1'b1 || rvalid !== 1'b0) begin n_fail++; $display("FAIL flush_rsp idle: gnt %0b rvalid %0b want 1/0", gnt, rvalid); end
        m_valid = 1'b0;
        a = '{64'h810};
        test_fetch_list("flush_rsp_refetch", a);
    endtask

    task automatic test_flush_req();
        logic [63:0] a [$];
        @(negedge clk); fetch_req = 1'b1; fetch_addr = 64'h818;
        @(posedge clk);
        @(negedge clk); fetch_req = 1'b0; flush = 1'b1; #1;
        n_checks++; if (rom_req !== 1'b1 || rom_addr !== 64'h818) begin n_fail++; $display("FAIL flush_req rom_req: got %0b/%h want 1/818", rom_req, rom_addr); end
        @(negedge clk); flush = 1'b0; #1;
        n_checks++; if (rvalid !== 1'b0 || gnt !== 1'b1) begin n_fail++; $display("FAIL flush_req after: rvalid %0b gnt %0b want 0/1", rvalid, gnt); end
        m_valid = 1'b0;
        a = '{64'h810, 64'h814};
        test_fetch_list("flush_req_refetch", a);
    endtask

    task automatic test_flush_idle();
        logic [63:0] a [$];
        @(negedge clk); flush = 1'b1; fetch_req = 1'b1; fetch_addr = 64'h814; #1;
        n_checks++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL flush_idle gnt: got %0b want 0", gnt); end
        @(negedge clk); flush = 1'b0; fetch_req = 1'b0; #1;
        n_checks++; if (rvalid !== 1'b0 || rom_req !== 1'b0) begin n_fail++; $display("FAIL flush_idle no_accept: rvalid %0b rom_req %0b want 0/0", rvalid, rom_req); end
        m_valid = 1'b0;
        a = '{64'h814};
        test_fetch_list("flush_idle_refetch", a);
    endtask

    task automatic test_reset_mid_miss();
        logic [63:0] a [$];
        a = '{64'h800};
        test_fetch_list("pre_reset_fill", a);
        @(negedge clk); fetch_req = 1'b1; fetch_addr = 64'h808;
        @(posedge clk);
        @(negedge clk); fetch_req = 1'b0;
        n_checks++; if (rom_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid rom_req before: got %0b want 1", rom_req); end
        rst = 1'b1; #1;
        n_checks++; if (rom_req !== 1'b0 || rom_addr !== 64'h0 || rvalid !== 1'b0 || gnt !== 1'b0)
            begin n_fail++; $display("FAIL rst_mid outputs: rom_req %0b rom_addr %h rvalid %0b gnt %0b want 0", rom_req, rom_addr, rvalid, gnt); end
        @(negedge clk); rst = 1'b0; #1;
        n_checks++; if (rvalid !== 1'b0 || gnt !== 1'b1) begin n_fail++; $display("FAIL rst_mid idle: rvalid %0b gnt %0b want 0/1", rvalid, gnt); end
        m_valid = 1'b0;
        test_fetch_list("post_reset_miss", a);
    endtask

    task automatic test_random();
        logic [63:0] a [$];
        for (int i = 0; i < 120; i++) begin
            a = {};
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: a.push_back(64'h800 + 64'(4 * $urandom_range(0, 39)));
                5: a.push_back(64'h8A0 + 64'(4 * $urandom_range(0, 100)));
                6: a.push_back(64'h800 - 64'(4 * $urandom_range(1, 200)));
                7: a.push_back(64'h800 + 64'(4 * $urandom_range(0, 39)) + 64'($urandom_range(1, 3)));
                8: a.push_back(64'h800 + 64'(8 * $urandom_range(0, 19)) + 64'(4 * $urandom_range(0, 1)));
                default: begin
                    @(negedge clk); flush = 1'b1;
                    @(negedge clk); flush = 1'b0;
                    m_valid = 1'b0;
                    a.push_back(64'h800 + 64'(4 * $urandom_range(0, 39)));
                end
            endcase
            test_fetch_list("random", a);
        end
    endtask

    initial begin
        for (int i = 0; i < 20; i++) mem[i] = {$urandom, $urandom};
        mem[0]  = {32'h0000_0013, 32'h0180_006f};
        mem[2]  = {32'h1234_5678, 32'h0000_0013};
        mem[19] = {32'h7b20_0073, 32'h7b20_2473};
        rst = 1'b1; flush = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
        m_valid = 1'b0; m_line = '0;
        test_reset();
        test_cold_and_hit();
        test_last_word();
        test_errors();
        test_flush_rsp();
        test_flush_req();
        test_flush_idle();
        test_reset_mid_miss();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_rom_fetch.md
Name: debug_rom_fetch

Overview:
Instruction-fetch initiator for the debug ROM. It sits between a hart's 32-bit fetch port and the 64-bit, one-cycle-latency debug ROM read port. It issues ROM reads and holds one 64-bit line buffer so that sequential fetches within a line do not re-read the ROM. It returns 32-bit instructions and flags accesses that are out of range or misaligned.

Parameters:
BaseAddr, 64'h0000_0000_0000_0800, byte address of ROM word 0 in the debug address map
RomSize, 20, number of 64-bit ROM words
AddrWidth, 64, fetch and ROM address width

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  reset; asynchronous, active-high
flush_i  in  1  invalidates the line buffer and aborts any in-flight fetch
fetch_req_i  in  1  fetch request from the hart
fetch_addr_i  in  AddrWidth  byte address of the fetch
fetch_gnt_o  out  1  request accepted this cycle
fetch_rvalid_o  out  1  response valid
fetch_rdata_o  out  32  instruction word
fetch_err_o  out  1  error response, qualified by fetch_rvalid_o
rom_req_o  out  1  ROM read request
rom_addr_o  out  AddrWidth  ROM byte address, always 8-byte aligned
rom_rdata_i  in  64  ROM data, valid the cycle after rom_req_o

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-high, on rst_i.
- Reset state:
  - state = IDLE, line valid = 0, tag = 0, buffer = 0, captured address = 0.
  - All outputs are 0.
- ROM contract: a request in cycle N gives data in cycle N+1. The ROM holds its address when not requested.
- Offset and checks:
  - off = fetch_addr_i - BaseAddr.
  - in_range = (fetch_addr_i >= BaseAddr) && (off < RomSize*8).
  - aligned = (fetch_addr_i[1:0] == 0).
  - Line index = off[..:3]. Half select = off[2]: 0 returns bits [31:0], 1 returns bits [63:32] (little-endian).
  - Hit = line valid && tag == line index.
- States: IDLE, HIT_RSP, ERR_RSP, ROM_REQ, ROM_RSP.
- fetch_gnt_o = (state == IDLE) && !flush_i. Only one request is outstanding at a time.
- IDLE:
  - On accept (fetch_req_i && fetch_gnt_o), capture the address, then:
  - if !in_range or !aligned, go to ERR_RSP;
  - else if hit, go to HIT_RSP;
  - else go to ROM_REQ.
- HIT_RSP: fetch_rvalid_o = 1, fetch_rdata_o = selected half of the buffer, fetch_err_o = 0. Next state IDLE.
- ERR_RSP: fetch_rvalid_o = 1, fetch_err_o = 1, fetch_rdata_o = 0. No ROM access. Next state IDLE.
- ROM_REQ: rom_req_o = 1, rom_addr_o = BaseAddr + {line index, 3'b000}. Next state ROM_RSP.
- ROM_RSP:
  - Drive fetch_rvalid_o = 1 with the selected half of rom_rdata_i, passed through combinationally.
  - Write rom_rdata_i into the buffer, set tag = line index, set valid = 1.
  - Next state IDLE.
- Latency from the accept cycle: hit or error returns rvalid at +1; miss returns rvalid at +2.
- rom_addr_o is 0 whenever rom_req_o = 0.
- fetch_rdata_o and fetch_err_o are 0 whenever fetch_rvalid_o = 0.
- flush_i, which has priority over all events:
  - Line valid is cleared at the next edge.
  - In any non-IDLE state: fetch_rvalid_o is forced to 0 that cycle, no buffer write occurs, next state is IDLE.
  - In ROM_REQ, rom_req_o is still driven. The returned data is ignored.
  - In IDLE with fetch_req_i: no grant.
- Boundaries:
  - Last word (off = RomSize*8-4) is legal.
  - off = RomSize*8 is an error.
  - Addresses below BaseAddr are an error; no wrap-around in the offset compare.
- Reset mid-miss: returns to IDLE with the buffer invalid, and there is no response.

Decomposition:
- Package debug_rom_pkg holds:
  - the fetch_state_e enum;
  - DbgRomBase and DbgRomSize constants, shared with debug_rom;
  - a function rom_line_idx().
- One sub-module is natural: debug_rom_linebuf, holding the 64-bit data, tag, valid, hit compare and half select.

Test Plan:
- Cold fetch 0x800 after reset → grant at cycle 0; rom_req_o = 1, rom_addr_o = 0x800 at cycle 1; rvalid, rdata = 0x0180006f, err = 0 at cycle 2.
- Fetch 0x804 right after the previous case → no rom_req_o; rvalid at +1, rdata = 0x00000013.
- Fetch 0x89C (last word) → miss via ROM address 0x898; rdata = 0x7b200073. Then fetch 0x898 hits with rdata = 0x7b202473.
- Fetch 0x8A0, then 0x7FC, then 0x802 → each gives rvalid with err = 1 and rdata = 0 at +1; rom_req_o never asserted.
- Miss to 0x810 with flush_i in the ROM_RSP cycle → no rvalid. A refetch of 0x810 re-reads the ROM (miss latency 2) and returns 0x00000013.
- Assert rst_i during ROM_REQ → outputs 0 immediately, state IDLE. The next fetch of 0x800 is a miss.
